// File: rtl/chaotic_sbox_generator_param_pkg.sv
// ---------------------------------------------------------------------------
// chaotic_sbox_generator_param_pkg : FSM encoding, S-box depth and XOR-fold.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package chaotic_sbox_generator_param_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    FALLBACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int MAX_BITS = 16;
  localparam int MAX_WORD = 256;

  function automatic int sbox_depth(input int bits);
    return 1 << bits;
  endfunction

  // Bit i of the word lands in result bit (i mod bits), which is the XOR of
  // all bits-wide slices with the top slice zero-padded.
  function automatic logic [MAX_BITS-1:0] xor_fold(input logic [MAX_WORD-1:0] word,
                                                   input int width,
                                                   input int bits);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_WORD; i++) begin
      if (i < width) r[4'(i % bits)] = r[4'(i % bits)] ^ word[8'(i)];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chaotic_sbox_generator_param_sbox_dual_table.sv
// ---------------------------------------------------------------------------
// sbox_dual_table : forward/inverse S-box storage, used bitmap, registered read.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sbox_dual_table
  import chaotic_sbox_generator_param_pkg::*;
#(
  parameter int BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [BITS-1:0]                wr_idx,
  input  logic [BITS-1:0]                wr_val,
  input  logic                           rd_en,
  input  logic                           rd_inv,
  input  logic [BITS-1:0]                rd_addr,
  output logic [BITS-1:0]                rd_data,
  output logic                           rd_valid,
  output logic [sbox_depth(BITS)-1:0]    used
);

  localparam int DEPTH = sbox_depth(BITS);

  logic [BITS-1:0] fwd_mem [DEPTH];
  logic [BITS-1:0] inv_mem [DEPTH];

  // Table contents need no reset: the used bitmap alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fwd_mem[wr_idx] <= wr_val;
      inv_mem[wr_val] <= wr_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      used <= '0;
    end else if (wr_en) begin
      used[wr_val] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= rd_inv ? inv_mem[rd_addr] : fwd_mem[rd_addr];
      rd_valid <= 1'b1;
    end else begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/chaotic_sbox_generator_param.sv
// ---------------------------------------------------------------------------
// chaotic_sbox_generator_param : builds a bijective S-box from chaotic words.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module chaotic_sbox_generator_param
  import chaotic_sbox_generator_param_pkg::*;
#(
  parameter int SBOX_BITS  = 8,
  parameter int NUM_CH     = 3,
  parameter int CH_WIDTH   = 32,
  parameter int MAX_REJECT = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_bar,
  input  logic                         start,
  input  logic [NUM_CH*CH_WIDTH-1:0]   chaos_in,
  input  logic                         chaos_valid,
  input  logic                         rd_en,
  input  logic                         rd_inv,
  input  logic [SBOX_BITS-1:0]         rd_addr,
  output logic [SBOX_BITS-1:0]         rd_data,
  output logic                         rd_valid,
  output logic                         ready,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         fallback_count
);

  localparam int DEPTH = sbox_depth(SBOX_BITS);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REJ_W = $clog2(MAX_REJECT + 1);
  localparam logic [SBOX_BITS-1:0] LAST_IDX = '1;

  state_t               state, state_nx;
  logic [SBOX_BITS-1:0] idx, idx_nx;
  logic [SBOX_BITS-1:0] scan_ptr, scan_nx;
  logic [PTR_W-1:0]     ch_ptr, ch_nx;
  logic [REJ_W-1:0]     reject_run, rej_nx;
  logic [CNT_WIDTH-1:0] cnt_nx;

  logic [CH_WIDTH-1:0]  ch_word;
  logic [SBOX_BITS-1:0] cand;
  logic [DEPTH-1:0]     used;
  logic                 wr_en;
  logic [SBOX_BITS-1:0] wr_val;
  logic                 clear;

  always_comb begin
    ch_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_ptr == PTR_W'(k)) ch_word = chaos_in[k*CH_WIDTH +: CH_WIDTH];
    end
    cand = SBOX_BITS'(xor_fold(MAX_WORD'(ch_word), CH_WIDTH, SBOX_BITS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      scan_ptr       <= '0;
      ch_ptr         <= '0;
      reject_run     <= '0;
      fallback_count <= '0;
    end else begin
      state          <= state_nx;
      idx            <= idx_nx;
      scan_ptr       <= scan_nx;
      ch_ptr         <= ch_nx;
      reject_run     <= rej_nx;
      fallback_count <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    scan_nx  = scan_ptr;
    ch_nx    = ch_ptr;
    rej_nx   = reject_run;
    cnt_nx   = fallback_count;
    wr_en    = 1'b0;
    wr_val   = cand;
    clear    = 1'b0;
    case (state)
      IDLE: begin
        if (!enable_bar) state_nx = FILL;
      end
      FILL: begin
        if (!enable_bar && chaos_valid) begin
          ch_nx = (ch_ptr == PTR_W'(NUM_CH - 1)) ? '0 : ch_ptr + PTR_W'(1);
          if (!used[cand]) begin
            wr_en  = 1'b1;
            wr_val = cand;
            idx_nx = idx + SBOX_BITS'(1);
            rej_nx = '0;
            if (idx == LAST_IDX) state_nx = DONE;
          end else if (reject_run == REJ_W'(MAX_REJECT - 1)) begin
            rej_nx   = REJ_W'(MAX_REJECT);
            scan_nx  = '0;
            state_nx = FALLBACK;
          end else begin
            rej_nx = reject_run + REJ_W'(1);
          end
        end
      end
      FALLBACK: begin
        // Lowest unused value wins; a free slot always exists before DONE.
        if (!enable_bar) begin
          if (!used[scan_ptr]) begin
            wr_en    = 1'b1;
            wr_val   = scan_ptr;
            idx_nx   = idx + SBOX_BITS'(1);
            rej_nx   = '0;
            if (fallback_count != '1) cnt_nx = fallback_count + CNT_WIDTH'(1);
            state_nx = (idx == LAST_IDX) ? DONE : FILL;
          end else begin
            scan_nx = scan_ptr + SBOX_BITS'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          clear    = 1'b1;
          idx_nx   = '0;
          ch_nx    = '0;
          rej_nx   = '0;
          cnt_nx   = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ready = (state == DONE);
  assign busy  = (state == FILL) || (state == FALLBACK);

  sbox_dual_table #(
    .BITS (SBOX_BITS)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (wr_en),
    .wr_idx   (idx),
    .wr_val   (wr_val),
    .rd_en    (rd_en && (state == DONE)),
    .rd_inv   (rd_inv),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .used     (used)
  );

endmodule

`default_nettype wire

// File: tb/tb_chaotic_sbox_generator_param.sv
// ---------------------------------------------------------------------------
// tb_chaotic_sbox_generator_param : directed bench, 16-entry S-box, 2 channels.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_chaotic_sbox_generator_param;

  localparam int SB   = 4;
  localparam int NCH  = 2;
  localparam int CW   = 32;
  localparam int MR   = 4;
  localparam int CNTW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable_bar = 1'b1;
  logic            start = 1'b0;
  logic [NCH*CW-1:0] chaos_in = '0;
  logic            chaos_valid = 1'b0;
  logic            rd_en = 1'b0;
  logic            rd_inv = 1'b0;
  logic [SB-1:0]   rd_addr = '0;
  logic [SB-1:0]   rd_data;
  logic            rd_valid;
  logic            ready;
  logic            busy;
  logic [CNTW-1:0] fallback_count;

  int checks = 0;
  int failures = 0;
  logic [SB-1:0] exp_fwd [16];

  always #5 clk = ~clk;

  chaotic_sbox_generator_param #(
    .SBOX_BITS  (SB),
    .NUM_CH     (NCH),
    .CH_WIDTH   (CW),
    .MAX_REJECT (MR),
    .CNT_WIDTH  (CNTW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable_bar     (enable_bar),
    .start          (start),
    .chaos_in       (chaos_in),
    .chaos_valid    (chaos_valid),
    .rd_en          (rd_en),
    .rd_inv         (rd_inv),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .ready          (ready),
    .busy           (busy),
    .fallback_count (fallback_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Folds to p across several nibbles: p ^ A ^ A ^ 5 ^ 5.
  function automatic logic [31:0] mkw(input logic [3:0] p);
    return {p, 4'h0, 4'hA, 4'hA, 4'h5, 4'h0, 4'h0, 4'h5};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    enable_bar = 1'b1;
    chaos_valid = 1'b0;
    repeat (3) begin
      chaos_in = {$urandom, $urandom};
      @(negedge clk);
    end
    reset = 1'b0;
  endtask

  task automatic enter_fill();
    enable_bar = 1'b0;
    chaos_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_enable", 32'(busy), 32'd1);
  endtask

  task automatic do_read(input logic inv, input logic [3:0] addr, input logic [3:0] exp,
                         input string tag);
    rd_en = 1'b1;
    rd_inv = inv;
    rd_addr = addr;
    @(negedge clk);
    rd_en = 1'b0;
    chk($sformatf("%s_valid[%0d]", tag, addr), 32'(rd_valid), 32'd1);
    chk($sformatf("%s[%0d]", tag, addr), 32'(rd_data), 32'(exp));
  endtask

  task automatic check_tables(input string tag);
    for (int i = 0; i < 16; i++) do_read(1'b0, 4'(i), exp_fwd[i], {tag, "_fwd"});
    for (int i = 0; i < 16; i++) do_read(1'b1, exp_fwd[i], 4'(i), {tag, "_inv"});
  endtask

  // Sample j carries candidate (coef*j+off)%16 on channel j%2; the other
  // channel carries a decoy so a wrong channel pointer corrupts the table.
  task automatic run_stream(input int coef, input int off, input int first, input int last);
    for (int j = first; j < last; j++) begin
      logic [3:0] p;
      p = 4'((coef * j + off) % 16);
      exp_fwd[j] = p;
      if (j % 2 == 1) chaos_in = {mkw(p), mkw(p ^ 4'h9)};
      else            chaos_in = {mkw(p ^ 4'h9), mkw(p)};
      chaos_valid = 1'b1;
      @(negedge clk);
    end
    chaos_valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound, input string tag);
    int n;
    n = 0;
    while (!ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    // 1: reset values and a read outside DONE
    @(negedge clk);
    do_reset();
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fallback", 32'(fallback_count), 32'd0);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_rd_data", 32'(rd_data), 32'd0);

    // 2: words 0..15 give the identity permutation
    enter_fill();
    for (int k = 0; k < 16; k++) begin
      chaos_in = {32'(k), 32'(k)};
      exp_fwd[k] = 4'(k);
      chaos_valid = 1'b1;
      @(negedge clk);
      if (k == 14) chk("ident_ready_early", 32'(ready), 32'd0);
    end
    chaos_valid = 1'b0;
    chk("ident_ready", 32'(ready), 32'd1);
    chk("ident_busy", 32'(busy), 32'd0);
    chk("ident_fallback", 32'(fallback_count), 32'd0);
    check_tables("ident");

    // 3: constant word 5 drives fallback for every other entry
    do_reset();
    enter_fill();
    chaos_in = {32'h5, 32'h5};
    chaos_valid = 1'b1;
    wait_ready(400, "const");
    chaos_valid = 1'b0;
    exp_fwd = '{4'd5, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7,
                4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    chk("const_fallback", 32'(fallback_count), 32'd15);
    do_read(1'b1, 4'd5, 4'd0, "const_inv5");
    do_read(1'b1, 4'd0, 4'd1, "const_inv0");
    check_tables("const");

    // 6: start in DONE with a same-cycle read returning old data
    rd_en = 1'b1;
    rd_inv = 1'b0;
    rd_addr = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_en = 1'b0;
    chk("start_rd_valid", 32'(rd_valid), 32'd1);
    chk("start_rd_old", 32'(rd_data), 32'd5);
    chk("start_ready", 32'(ready), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_fallback_clr", 32'(fallback_count), 32'd0);
    run_stream(5, 1, 0, 16);
    chk("regen_ready", 32'(ready), 32'd1);
    chk("regen_fallback", 32'(fallback_count), 32'd0);
    check_tables("regen");

    // 4: stalls mid-FILL freeze idx and ch_ptr; start ignored outside DONE
    do_reset();
    enter_fill();
    run_stream(7, 3, 0, 6);
    enable_bar = 1'b1;
    chaos_valid = 1'b1;
    for (int s = 0; s < 5; s++) begin
      chaos_in = {$urandom, $urandom};
      start = (s == 2);
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_busy", 32'(busy), 32'd1);
    enable_bar = 1'b0;
    chaos_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chaos_in = {$urandom, $urandom};
      @(negedge clk);
    end
    chk("stall_ready", 32'(ready), 32'd0);
    run_stream(7, 3, 6, 16);
    chk("stall_done", 32'(ready), 32'd1);
    chk("stall_fallback", 32'(fallback_count), 32'd0);
    check_tables("stall");

    // 5: reset after 7 entries, then the same stream uninterrupted
    do_reset();
    enter_fill();
    run_stream(7, 3, 0, 7);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", 32'(ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_fallback", 32'(fallback_count), 32'd0);
    enter_fill();
    run_stream(7, 3, 0, 16);
    chk("rerun_done", 32'(ready), 32'd1);
    chk("rerun_fallback", 32'(fallback_count), 32'd0);
    check_tables("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/chaotic_sbox_generator_param.md
Name: chaotic_sbox_generator_param

Overview:
Parametrised successor to the fixed 16x16 chaotic S-box generator. Consumes NUM_CH chaotic words from chaos_generator and builds a bijective 2^SBOX_BITS-entry substitution table with its inverse, using duplicate rejection and a bounded deterministic fallback. Results are exposed through a registered read port rather than a full-array output. Supports regeneration on demand. Sits between chaos_generator and the encryption datapath, which uses the forward and inverse tables.

Parameters:
SBOX_BITS, 8, entry width; table depth = 2^SBOX_BITS
NUM_CH, 3, number of chaotic channels
CH_WIDTH, 32, width of each chaotic word
MAX_REJECT, 16, consecutive duplicate candidates tolerated before fallback
CNT_WIDTH, 16, width of fallback_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enable_bar  in  1  active-low run enable; high stalls generation
start  in  1  one-cycle pulse; regenerates the table when in DONE
chaos_in  in  NUM_CH*CH_WIDTH  chaotic words; channel k at [k*CH_WIDTH +: CH_WIDTH]
chaos_valid  in  1  chaos_in holds a fresh sample
rd_en  in  1  read request
rd_inv  in  1  0 = forward table, 1 = inverse table
rd_addr  in  SBOX_BITS  table index
rd_data  out  SBOX_BITS  registered read data
rd_valid  out  1  rd_data valid
ready  out  1  table complete
busy  out  1  generation in progress
fallback_count  out  CNT_WIDTH  fallback insertions in the current table, saturating

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, ready=0, busy=0, fallback_count=0. Internal state: used bitmap=0, idx=0, ch_ptr=0, reject_run=0, state=IDLE.
- A reset in any state, including mid-FILL, aborts generation and returns to reset values. The next run is identical to a run from power-up.
- Candidate = XOR-fold of channel ch_ptr: XOR of all SBOX_BITS slices of the word, with the top slice zero-padded. ch_ptr advances mod NUM_CH on each consumed sample.
- IDLE: go to FILL on the first cycle enable_bar=0. busy=1 from that cycle.
- FILL: a sample is consumed only when chaos_valid=1 and enable_bar=0; otherwise all state holds.
  - If used[cand]=0: fwd[idx]=cand, inv[cand]=idx, used[cand]=1, idx++, reject_run=0.
  - Otherwise: reject_run++. On the MAX_REJECT-th consecutive reject, go to FALLBACK.
- FALLBACK: scan_ptr starts at 0 on entry and advances one per cycle. It ignores chaos_valid but stalls on enable_bar=1.
  - At the first unused value, insert it exactly as in FILL.
  - Then fallback_count++ (saturating), reject_run=0, return to FILL.
  - Worst case is 2^SBOX_BITS cycles.
- Completion: the write with idx=2^SBOX_BITS-1 moves to DONE. ready=1 and busy=0 from the next cycle.
- DONE:
  - start=1: clear used, idx, ch_ptr, reject_run and fallback_count; go to FILL. ready=0 and busy=1 next cycle.
  - start is ignored outside DONE.
- Read port, one-cycle latency:
  - rd_en=1 in DONE: next cycle rd_data = fwd[rd_addr] or inv[rd_addr] per rd_inv, rd_valid=1.
  - rd_en=0, or any state other than DONE: next cycle rd_valid=0, rd_data=0.
  - A read in the same cycle as start returns old table data.
- Invariant in DONE: fwd is a permutation and inv[fwd[i]]=i for all i.

Decomposition:
- Shared package holds: the state encoding (IDLE, FILL, FALLBACK, DONE), the XOR-fold function, and SBOX depth localparam derivation.
- One natural sub-module: sbox_dual_table. It holds the fwd/inv storage and used bitmap, with a single-cycle bitmap clear and a registered read port.
- The FSM, candidate selection and fallback scan stay in the top module.

Test Plan:
1. Reset held 3 cycles with random chaos_in -> all outputs 0. A rd_en pulse gives rd_valid=0.
2. SBOX_BITS=4, NUM_CH=1, chaos words 0x0000000k for k=0..15 on consecutive valid cycles -> identity fwd and inv tables, fallback_count=0. ready rises the cycle after the 16th accept.
3. SBOX_BITS=4, MAX_REJECT=4, constant word 0x00000005 ->
   - fwd = {5,0,1,2,3,4,6,7,...,15}, fallback_count=15.
   - Reads: rd_inv=1, rd_addr=5 -> 0; rd_inv=1, rd_addr=0 -> 1.
4. enable_bar=1, or chaos_valid=0, for 5 cycles mid-FILL -> no writes, idx and ch_ptr frozen. The final table equals a run without stalls on the same accepted-sample stream.
5. Reset asserted after 7 entries, then rerun with the same stream -> ready=0 immediately after reset. The final table is identical to an uninterrupted run.
6. start pulse in DONE with new seeds -> ready=0 next cycle and fallback_count cleared. The new table is a valid permutation with inv consistent. A read in the start cycle returns old data.
